seven_segs_scan_ctrl: RTL and testbench
=======================================

SEVEN_SEGS_SCAN_CTRL -- requirements
Module: seven_segs_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed display digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Clk  input  1  single clock, all state rising-edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Data  input  4*DIGITS  new display value; nibble k = digit k, digit 0 = bits 3:0.
REQ-006 Load  input  1  request to load Data; accepted only when Load and Ready are both high.
REQ-007 Ready  output  1  controller can accept a Load this cycle.
REQ-008 Blank  input  1  display disable, high = all digits dark.
REQ-009 Segs  output  7  segment pattern of the currently scanned digit, from the seven_segs decoder.
REQ-010 An  output  DIGITS  digit select, active-low, one bit low at a time when not blanked.

Function
REQ-011 Prescaler counts 0..DIV-1 and wraps; Tick is high for one cycle when the count equals DIV-1.
REQ-012 Digit index Idx advances by 1 on each Tick and wraps from DIGITS-1 to 0.
REQ-013 A frame boundary is a Tick cycle with Idx = DIGITS-1.
REQ-014 Shown register (4*DIGITS) holds the displayed value; Pend register holds an accepted but uncommitted value.
REQ-015 FSM states: IDLE (Ready=1) and PEND (Ready=0).
REQ-016 IDLE, Load high, not a frame boundary: Data -> Pend; next state PEND.
REQ-017 IDLE, Load high, on a frame boundary: Data -> Shown directly; state stays IDLE.
REQ-018 PEND, on a frame boundary: Pend -> Shown; next state IDLE, so Ready is high on the following cycle.
REQ-019 PEND: Load is ignored and Pend is not overwritten.
REQ-020 Displayed nibble register CurNib updates every cycle to Shown nibble [Idx after this edge], giving one registered cycle of latency from Idx to Segs.
REQ-021 Segs = seven_segs decode of CurNib with EnableSegs = ~BlankQ, where BlankQ is Blank registered once.
REQ-022 An registered: all ones if Blank was high in the prior cycle, otherwise ~(1 << Idx).
REQ-023 Blank affects only An and Segs; the prescaler, Idx, FSM and load handshake keep running.
REQ-024 A new Shown value first appears on the Idx = 0 slot following its commit, so a frame never mixes old and new digits.

Reset
REQ-025 With Rst_n low: prescaler = 0, Idx = 0, Shown = 0, Pend = 0, CurNib = 0, BlankQ = 1, state = IDLE.
REQ-026 During reset: An = all ones, Segs = decoder output with enable low (dark), Ready = 1.
REQ-027 Reset mid-PEND discards Pend; after release, the first Tick occurs DIV cycles later.

Structure
REQ-028 A shared package holds the default DIGITS and DIV, the FSM state encoding (IDLE = 0, PEND = 1), and the nibble width 4.
REQ-029 One sub-module: the existing seven_segs decoder, instantiated once and driven by CurNib and ~BlankQ.
REQ-030 No other hierarchy; the prescaler, index and FSM are local.

Verification
Bench parameters: DIGITS = 4, DIV = 4.
REQ-031 Reset, then release with Blank = 0 -> An sequence 1110, 1101, 1011, 0111, each held 4 cycles, wrapping; Segs shows the "0" pattern throughout.
REQ-032 Load of Data = 16'h4321 at a mid-frame cycle -> Ready drops the next cycle; Shown updates at the frame boundary; Ready rises one cycle later; the next frame shows 1, 2, 3, 4 on An bits 0..3.
REQ-033 Load asserted exactly on a frame boundary with 16'hABCD -> Ready never drops; the next frame shows D, C, B, A.
REQ-034 In PEND, a second Load of 16'hFFFF -> ignored; the committed value is the first Load.
REQ-035 Blank held high for 10 cycles -> An = 1111 from the cycle after assertion; Segs dark; Idx continues advancing (the digit after release matches the free-running count).
REQ-036 Rst_n pulsed low while in PEND -> An = 1111, Ready = 1, Shown = 0 immediately; the pending value never appears.

Source files
------------

// File: rtl/seven_segs_scan_ctrl_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// default geometry, nibble width and the load-handshake FSM encoding.
package seven_segs_scan_ctrl_pkg;

    localparam int DIGITS_DEF = 8;
    localparam int DIV_DEF    = 50000;
    localparam int NIB_W      = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

endpackage

// File: rtl/seven_segs_scan_ctrl_seven_segs.sv
// seven_segs: hex nibble to seven-segment decoder, active-high segments.
//   nib         in  4  value to show (0..F)
//   enable_segs in  1  low forces all segments dark
//   segs        out 7  {g,f,e,d,c,b,a}
module seven_segs
    import seven_segs_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    input  logic             enable_segs,
    output logic [6:0]       segs
);

    always_comb begin
        segs = 7'h00;
        if (enable_segs) begin
            case (nib)
                4'h0: segs = 7'h3F;
                4'h1: segs = 7'h06;
                4'h2: segs = 7'h5B;
                4'h3: segs = 7'h4F;
                4'h4: segs = 7'h66;
                4'h5: segs = 7'h6D;
                4'h6: segs = 7'h7D;
                4'h7: segs = 7'h07;
                4'h8: segs = 7'h7F;
                4'h9: segs = 7'h6F;
                4'hA: segs = 7'h77;
                4'hB: segs = 7'h7C;
                4'hC: segs = 7'h39;
                4'hD: segs = 7'h5E;
                4'hE: segs = 7'h79;
                default: segs = 7'h71;
            endcase
        end
    end

endmodule

// File: rtl/seven_segs_scan_ctrl.sv
// seven_segs_scan_ctrl: time-multiplexed scan of DIGITS seven-segment digits
// with a frame-synchronous load handshake.
//   clk    in   1          rising-edge clock
//   rst_n  in   1          async active-low reset
//   data   in   4*DIGITS   new display value, digit 0 in bits 3:0
//   load   in   1          load request, taken when load && ready
//   ready  out  1          a load can be accepted this cycle
//   blank  in   1          high darkens the display (scan keeps running)
//   segs   out  7          segments of the currently selected digit
//   an     out  DIGITS     active-low digit select
//
// state | meaning
// IDLE  | no value waiting; ready high
// PEND  | accepted value held in pend until the next frame boundary
module seven_segs_scan_ctrl
    import seven_segs_scan_ctrl_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int DIV    = DIV_DEF
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NIB_W*DIGITS-1:0] data,
    input  logic                    load,
    output logic                    ready,
    input  logic                    blank,
    output logic [6:0]              segs,
    output logic [DIGITS-1:0]       an
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nxt;
    logic                    tick;
    logic                    frame;
    logic [0:0]              state;
    logic [NIB_W*DIGITS-1:0] shown;
    logic [NIB_W*DIGITS-1:0] shown_nxt;
    logic [NIB_W*DIGITS-1:0] pend;
    logic [NIB_W-1:0]        cur_nib;
    logic                    blank_q;

    assign tick  = (cnt == CNT_LAST);
    assign frame = tick && (idx == IDX_LAST);
    assign ready = (state == ST_IDLE);

    always_comb begin
        idx_nxt = idx;
        if (tick) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    // Commits only happen on a frame boundary, where idx wraps to 0 on the
    // same edge, so a new value always starts at the first digit of a frame.
    always_comb begin
        shown_nxt = shown;
        if (frame) begin
            if (state == ST_PEND) begin
                shown_nxt = pend;
            end else if (load) begin
                shown_nxt = data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + PW'(1);
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pend  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load && !frame) begin
                        pend  <= data;
                        state <= ST_PEND;
                    end
                end
                default: begin
                    if (frame) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Display path uses next-edge idx/shown so cur_nib and an stay aligned
    // with the idx register they are derived from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown   <= '0;
            cur_nib <= '0;
            blank_q <= 1'b1;
            an      <= '1;
        end else begin
            shown   <= shown_nxt;
            cur_nib <= shown_nxt[idx_nxt*NIB_W +: NIB_W];
            blank_q <= blank;
            an      <= blank ? '1 : ~(DIGITS'(1) << idx_nxt);
        end
    end

    seven_segs u_seven_segs (
        .nib         (cur_nib),
        .enable_segs (~blank_q),
        .segs        (segs)
    );

endmodule

// File: tb/tb_seven_segs_scan_ctrl.sv
// Directed bench for seven_segs_scan_ctrl with DIGITS=4, DIV=4 (16-cycle
// frame). Each table row holds inputs for N cycles and the outputs expected
// 1 time unit after every rising edge of those cycles.
module tb_seven_segs_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
    localparam logic [6:0] S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07;
    localparam logic [6:0] S8 = 7'h7F, SA = 7'h77, SB = 7'h7C, SC = 7'h39;
    localparam logic [6:0] SD = 7'h5E, DK = 7'h00;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] data  = 16'h0000;
    logic        ready;
    logic [6:0]  segs;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    seven_segs_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .load  (load),
        .ready (ready),
        .blank (blank),
        .segs  (segs),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        blank;
        logic        load;
        logic [15:0] data;
        int          cycles;
        logic [3:0]  an;
        logic [6:0]  segs;
        logic        ready;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic l,
                       input logic [15:0] d, input int n,
                       input logic [3:0] a, input logic [6:0] s,
                       input logic rdy);
        vec_t v;
        v.rst_n = r; v.blank = b; v.load = l; v.data = d; v.cycles = n;
        v.an = a; v.segs = s; v.ready = rdy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row,
                         input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d t=%0t got=%h expected=%h",
                     name, row, $time, act, exp);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                @(negedge clk);
                rst_n = vecs[i].rst_n;
                blank = vecs[i].blank;
                load  = vecs[i].load;
                data  = vecs[i].data;
                @(posedge clk);
                #1;
                check("an",    i, {3'b000, an},    {3'b000, vecs[i].an});
                check("segs",  i, segs,            vecs[i].segs);
                check("ready", i, {6'd0, ready},   {6'd0, vecs[i].ready});
            end
        end
    endtask

    int split;

    initial begin
        // reset, then free-running scan of all zeros
        add(0, 0, 0, 16'h0000, 2, 4'hF, DK, 1);
        add(1, 0, 0, 16'h0000, 3, 4'hE, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hD, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hB, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hE, S0, 1);
        // mid-frame load of 4321: pending until the boundary
        add(1, 0, 1, 16'h4321, 1, 4'hD, S0, 0);
        add(1, 0, 0, 16'h0000, 3, 4'hD, S0, 0);
        add(1, 0, 0, 16'h0000, 4, 4'hB, S0, 0);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S0, 0);
        add(1, 0, 0, 16'h0000, 4, 4'hE, S1, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hD, S2, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hB, S3, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S4, 1);
        // load exactly on the boundary: direct commit, ready stays high
        add(1, 0, 1, 16'hABCD, 1, 4'hE, SD, 1);
        add(1, 0, 0, 16'h0000, 3, 4'hE, SD, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hD, SC, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hB, SB, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, SA, 1);
        // load 8765, then FFFF while pending must be ignored
        add(1, 0, 0, 16'h0000, 2, 4'hE, SD, 1);
        add(1, 0, 1, 16'h8765, 1, 4'hE, SD, 0);
        add(1, 0, 1, 16'hFFFF, 1, 4'hE, SD, 0);
        add(1, 0, 0, 16'h0000, 4, 4'hD, SC, 0);
        add(1, 0, 0, 16'h0000, 4, 4'hB, SB, 0);
        add(1, 0, 0, 16'h0000, 4, 4'h7, SA, 0);
        add(1, 0, 0, 16'h0000, 4, 4'hE, S5, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hD, S6, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hB, S7, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S8, 1);
        // blank for 10 cycles; scan resumes at the free-running position
        add(1, 1, 0, 16'h0000, 10, 4'hF, DK, 1);
        add(1, 0, 0, 16'h0000, 2, 4'hB, S7, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S8, 1);
        // enter PEND with 2222 ahead of a reset pulse
        add(1, 0, 0, 16'h0000, 1, 4'hE, S5, 1);
        add(1, 0, 1, 16'h2222, 1, 4'hE, S5, 0);
        add(1, 0, 0, 16'h0000, 1, 4'hE, S5, 0);
        split = vecs.size();
        // after reset: zeros again, first tick DIV cycles after release
        add(0, 0, 0, 16'h0000, 1, 4'hF, DK, 1);
        add(1, 0, 0, 16'h0000, 3, 4'hE, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hD, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hB, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'h7, S0, 1);
        add(1, 0, 0, 16'h0000, 4, 4'hE, S0, 1);

        run(0, split);

        // asynchronous reset while pending: outputs clear before any edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_an",    -1, {3'b000, an},  7'h0F);
        check("rst_async_ready", -1, {6'd0, ready}, 7'h01);
        check("rst_async_segs",  -1, segs,          DK);

        run(split, vecs.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
